data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised, clocked data memory for the homework CPU datapath. It stores DEPTH 32-bit words and is addressed by byte address. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. A valid/ready request port and a one-cycle response pulse give it a configurable access latency, and misaligned or out-of-range accesses are flagged as errors. After reset, a hardware sweep clears the whole array before the first request is accepted.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 1: cycles from request accept to response; ≥ 1.
- clk  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  input  32  store data; the low 8/16/32 bits are used according to size.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_error  output  1  request was illegal; qualified by resp_valid.

## Operation
- **States:** CLEAR, IDLE, WAIT.
- **Reset:** every cycle with reset=1 forces state CLEAR, clear index 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0. Any in-flight request is discarded and no response is ever produced for it.
- **CLEAR:** one word per cycle, memory[idx] ← 0 and idx++. After word DEPTH-1 is written, go to IDLE. req_valid is ignored during CLEAR.
- **Accept:** a request is accepted when req_valid && req_ready at a rising edge (cycle T).
- **Word index:** req_addr[2 +: log2(DEPTH)]. The byte lane is req_addr[1:0], little-endian: byte 0 is bits [7:0].
- **Errors:** an accepted request is illegal if any of the following holds:
  - req_size = 3;
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - req_addr ≥ 4·DEPTH.
- **Illegal requests:** no memory update, resp_error=1, resp_rdata=0.
- **Store:** only the addressed lanes are written, at the accept edge. Other bytes of the word are unchanged. The response has resp_rdata=0 and resp_error=0.
- **Load:** the word is read as it stands at the accept edge. The lane is extracted and extended to 32 bits per req_unsigned.
- **Request handling:** a LATENCY-deep pipeline or counter carries the result. In IDLE with LATENCY>1, an accept moves the state to WAIT. It returns to IDLE in the response cycle. With LATENCY=1 the block stays in IDLE.
- **Outstanding requests:** only one request is outstanding at a time.

## Timing
- **Clear duration:** with the first cycle of reset=0 as cycle 0, the clear runs in cycles 0..DEPTH-1. req_ready first rises in cycle DEPTH.
- **Response:** for a request accepted in cycle T, resp_valid=1 in cycle T+LATENCY only. resp_rdata and resp_error are valid in that cycle and are 0 whenever resp_valid=0.
- **Ready:** req_ready=0 in cycles T+1..T+LATENCY-1 and 1 again in cycle T+LATENCY. A new request may be accepted in the response cycle.
- **Throughput:** one request per LATENCY cycles. With LATENCY=1, back-to-back accepts every cycle.
- **Read-after-write:** a store accepted in cycle T is visible to a load accepted in cycle T+1 or later. No bypass is needed, because the write commits at the accept edge.
- **Reset during WAIT or in the response cycle:** resp_valid=0 from the next cycle, and the clear restarts from index 0.
- **Held requests:** req_valid held high while req_ready=0 is neither accepted nor queued. It is sampled again once req_ready=1.

## Test plan
1. **Reset and clear (DEPTH=256, LATENCY=1):** release reset, hold req_valid=1 with a load from 0x10. Required: req_ready=0 in cycles 0–255 and 1 in cycle 256. The load is accepted in cycle 256, resp_valid=1 in cycle 257 with resp_rdata=0x00000000.
2. **Byte-lane stores and signed/unsigned loads:** store word 0xDEADBEEF at 0x20, then byte 0x80 at 0x21. Required loads:
   - word at 0x20 → 0xDEAD80EF;
   - signed byte at 0x21 → 0xFFFFFF80;
   - unsigned byte at 0x21 → 0x00000080;
   - signed half at 0x22 → 0xFFFFDEAD.
3. **Errors (each must produce resp_error=1, resp_rdata=0, and leave memory unchanged):** store word at 0x06 (word at 0x04 still reads 0); half load at 0x03; size=3 at 0x00; word load at 0x400 with DEPTH=256.
4. **Latency and handshake (LATENCY=3):** accept at T. Required: req_ready=0 at T+1 and T+2; resp_valid only at T+3 with req_ready=1. A second request accepted at T+3 responds at T+6.
5. **Back-to-back (LATENCY=1):** store 0x12345678 to 0x40 in cycle T, load 0x40 in cycle T+1. Required: responses in T+1 and T+2, the load returning 0x12345678.
6. **Reset mid-operation (LATENCY=4):** accept a load at T, assert reset for one cycle at T+2. Required: no resp_valid at T+4, and req_ready next rises DEPTH cycles after reset is released.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory: valid/ready request, single-cycle response pulse.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with byte/half/word access, fixed response latency
// and a post-reset clear sweep that zeroes every word before the first request.
module data_memory_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] clr_idx;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   pend_rdata;
  logic          pend_error;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          illegal;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   cur_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_data;
  logic [31:0]   resp_word;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign word_idx      = bus.req_addr[2 +: AW];
  assign lane          = bus.req_addr[1:0];
  assign cur_word      = mem[word_idx];

  // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
  always_comb begin
    illegal = |bus.req_addr[31:AW+2];
    case (bus.req_size)
      2'd1:    illegal = illegal | lane[0];
      2'd2:    illegal = illegal | (|lane);
      2'd3:    illegal = 1'b1;
      default: illegal = illegal;
    endcase
  end

  always_comb begin
    byte_v    = cur_word[{lane, 3'b000} +: 8];
    half_v    = cur_word[{lane[1], 4'b0000} +: 16];
    load_data = '0;
    case (bus.req_size)
      2'd0:    load_data = {{24{~bus.req_unsigned & byte_v[7]}}, byte_v};
      2'd1:    load_data = {{16{~bus.req_unsigned & half_v[15]}}, half_v};
      2'd2:    load_data = cur_word;
      default: load_data = '0;
    endcase
    resp_word = (illegal || bus.req_write) ? 32'd0 : load_data;
  end

  // The array has a single write port shared by the clear sweep and stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = '0;
    mem_be    = '0;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we  = 1'b1;
        mem_idx = clr_idx;
        mem_be  = 4'hF;
      end else if (accept && bus.req_write && !illegal) begin
        mem_we = 1'b1;
        case (bus.req_size)
          2'd0: begin
            mem_wdata = {4{bus.req_wdata[7:0]}};
            mem_be    = 4'b0001 << lane;
          end
          2'd1: begin
            mem_wdata = {2{bus.req_wdata[15:0]}};
            mem_be    = lane[1] ? 4'b1100 : 4'b0011;
          end
          default: begin
            mem_wdata = bus.req_wdata;
            mem_be    = 4'hF;
          end
        endcase
      end
    end
  end

  // NOTE: the array has no reset term; the clear sweep zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // NOTE: sequential state is updated only with non-blocking '<=' so all registers sample together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_CLEAR;
      clr_idx        <= '0;
      wait_cnt       <= '0;
      pend_rdata     <= '0;
      pend_error     <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= resp_word;
              bus.resp_error <= illegal;
            end else begin
              pend_rdata <= resp_word;
              pend_error <= illegal;
              wait_cnt   <= CW'(LATENCY - 1);
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == CW'(1)) begin
            state          <= ST_IDLE;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= pend_rdata;
            bus.resp_error <= pend_error;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (latency 1/3/4) checked against a
// byte-array reference model with directed and random transactions.
module tb_data_memory_ctrl;
  localparam int D0 = 256, L0 = 1;
  localparam int D1 = 16,  L1 = 3;
  localparam int D2 = 16,  L2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst   = 3'b111;
  logic [2:0]  valid = 3'b000;
  logic        w_write = 1'b0;
  logic [31:0] w_addr  = '0;
  logic [1:0]  w_size  = '0;
  logic        w_uns   = 1'b0;
  logic [31:0] w_wdata = '0;

  logic [2:0]  rdy, rv, rerr;
  logic [31:0] rdata [3];

  int n_tests = 0;
  int n_fail  = 0;
  int dep [3] = '{D0, D1, D2};
  int lat [3] = '{L0, L1, L2};
  logic [7:0] mdl [3][1024];

  data_memory_ctrl_if bus0 ();
  data_memory_ctrl_if bus1 ();
  data_memory_ctrl_if bus2 ();

  assign bus0.req_valid = valid[0];  assign bus1.req_valid = valid[1];  assign bus2.req_valid = valid[2];
  assign bus0.req_write = w_write;   assign bus1.req_write = w_write;   assign bus2.req_write = w_write;
  assign bus0.req_addr  = w_addr;    assign bus1.req_addr  = w_addr;    assign bus2.req_addr  = w_addr;
  assign bus0.req_size  = w_size;    assign bus1.req_size  = w_size;    assign bus2.req_size  = w_size;
  assign bus0.req_unsigned = w_uns;  assign bus1.req_unsigned = w_uns;  assign bus2.req_unsigned = w_uns;
  assign bus0.req_wdata = w_wdata;   assign bus1.req_wdata = w_wdata;   assign bus2.req_wdata = w_wdata;

  assign rdy[0] = bus0.req_ready;  assign rv[0] = bus0.resp_valid;  assign rerr[0] = bus0.resp_error;  assign rdata[0] = bus0.resp_rdata;
  assign rdy[1] = bus1.req_ready;  assign rv[1] = bus1.resp_valid;  assign rerr[1] = bus1.resp_error;  assign rdata[1] = bus1.resp_rdata;
  assign rdy[2] = bus2.req_ready;  assign rv[2] = bus2.resp_valid;  assign rerr[2] = bus2.resp_error;  assign rdata[2] = bus2.resp_rdata;

  data_memory_ctrl #(.DEPTH(D0), .LATENCY(L0)) dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
  data_memory_ctrl #(.DEPTH(D1), .LATENCY(L1)) dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));
  data_memory_ctrl #(.DEPTH(D2), .LATENCY(L2)) dut2 (.clk(clk), .reset(rst[2]), .bus(bus2));

  task automatic model_clear(input int k);
    for (int i = 0; i < 1024; i++) mdl[k][i] = 8'h00;
  endtask

  function automatic logic legal(input int k, input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b0;
    if (s == 2'd1 && a[0]) return 1'b0;
    if (s == 2'd2 && a[1:0] != 2'b00) return 1'b0;
    if (a >= 32'(4 * dep[k])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [31:0] a, input logic [1:0] s, input logic u);
    int ai = int'(a);
    logic [7:0]  b;
    logic [15:0] h;
    case (s)
      2'd0: begin b = mdl[k][ai]; return u ? {24'h0, b} : {{24{b[7]}}, b}; end
      2'd1: begin h = {mdl[k][ai+1], mdl[k][ai]}; return u ? {16'h0, h} : {{16{h[15]}}, h}; end
      default: return {mdl[k][ai+3], mdl[k][ai+2], mdl[k][ai+1], mdl[k][ai]};
    endcase
  endfunction

  task automatic model_store(input int k, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = 1 << s;
    for (int i = 0; i < n; i++) mdl[k][int'(a) + i] = d[8*i +: 8];
  endtask

  // Issues one request on instance k and checks the full response timing against the model.
  task automatic do_req(input int k, input logic wr, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d,
                        output logic [31:0] got, output logic got_err, output int waited);
    logic [31:0] exp_d;
    logic        exp_e;
    got = 'x; got_err = 1'bx;
    w_write = wr; w_addr = a; w_size = s; w_uns = u; w_wdata = d;
    valid[k] = 1'b1;
    waited = 0;
    while (rdy[k] !== 1'b1 && waited < 5000) begin
      @(posedge clk); #1; waited++;
    end
    if (rdy[k] !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout k=%0d addr=%h: ready=%b after %0d cycles, required 1", k, a, rdy[k], waited);
      valid[k] = 1'b0;
      return;
    end
    exp_e = !legal(k, a, s);
    exp_d = (exp_e || wr) ? 32'h0 : model_load(k, a, s, u);
    if (!exp_e && wr) model_store(k, a, s, d);
    @(posedge clk); #1;
    valid[k] = 1'b0;
    for (int i = 1; i < lat[k]; i++) begin
      @(negedge clk);
      n_tests++;
      if (rv[k] !== 1'b0 || rdy[k] !== 1'b0 || rdata[k] !== 32'h0 || rerr[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_cycle k=%0d +%0d: valid=%b ready=%b rdata=%h error=%b, required 0 0 0 0",
                 k, i, rv[k], rdy[k], rdata[k], rerr[k]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (rv[k] !== 1'b1 || rdy[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_timing k=%0d addr=%h: valid=%b ready=%b, required 1 1", k, a, rv[k], rdy[k]);
    end
    n_tests++;
    if (rdata[k] !== exp_d || rerr[k] !== exp_e) begin
      n_fail++;
      $display("FAIL resp_value k=%0d wr=%b addr=%h size=%0d uns=%b: rdata=%h error=%b, required %h %b",
               k, wr, a, s, u, rdata[k], rerr[k], exp_d, exp_e);
    end
    got = rdata[k]; got_err = rerr[k];
  endtask

  task automatic test_reset();
    logic [31:0] got; logic e; int waited;
    rst = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdy[k] !== 1'b0 || rv[k] !== 1'b0 || rdata[k] !== 32'h0 || rerr[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d: ready=%b valid=%b rdata=%h error=%b, required 0 0 0 0",
                 k, rdy[k], rv[k], rdata[k], rerr[k]);
      end
    end
    @(posedge clk); #1;
    rst = 3'b000;
    for (int k = 0; k < 3; k++) model_clear(k);
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, got, e, waited);
    n_tests++;
    if (waited !== D0) begin
      n_fail++;
      $display("FAIL clear_duration: first ready in cycle %0d, required %0d", waited, D0);
    end
    n_tests++;
    if (got !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_load: rdata=%h, required 00000000", got);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] got; logic e; int w;
    logic [31:0] addrs [4] = '{32'h20, 32'h21, 32'h21, 32'h22};
    logic [1:0]  sizes [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
    logic        unss  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [4] = '{32'hDEAD80EF, 32'hFFFFFF80, 32'h00000080, 32'hFFFFDEAD};
    do_req(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'hDEADBEEF, got, e, w);
    do_req(0, 1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFFFF80, got, e, w);
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, addrs[i], sizes[i], unss[i], 32'h0, got, e, w);
      n_tests++;
      if (got !== exps[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL lane_load %0d addr=%h: rdata=%h error=%b, required %h 0", i, addrs[i], got, e, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] got; logic e; int w;
    logic        ewr  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] eadr [6] = '{32'h06, 32'h03, 32'h00, 32'h400, 32'h400, 32'h08};
    logic [1:0]  esz  [6] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3};
    logic [31:0] cadr [3] = '{32'h04, 32'h00, 32'h08};
    for (int i = 0; i < 6; i++) begin
      do_req(0, ewr[i], eadr[i], esz[i], 1'b0, 32'hA5A5A5A5, got, e, w);
      n_tests++;
      if (e !== 1'b1 || got !== 32'h0) begin
        n_fail++;
        $display("FAIL error_flag %0d addr=%h: error=%b rdata=%h, required 1 00000000", i, eadr[i], e, got);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b0, cadr[i], 2'd2, 1'b0, 32'h0, got, e, w);
      n_tests++;
      if (got !== 32'h0) begin
        n_fail++;
        $display("FAIL error_no_write addr=%h: rdata=%h, required 00000000", cadr[i], got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got; logic e; int w;
    do_req(0, 1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678, got, e, w);
    do_req(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, got, e, w);
    n_tests++;
    if (w !== 0 || got !== 32'h12345678) begin
      n_fail++;
      $display("FAIL back_to_back: wait=%0d rdata=%h, required 0 12345678", w, got);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (rv[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL resp_pulse: valid=%b rdata=%h one cycle after response, required 0 00000000", rv[0], rdata[0]);
    end
  endtask

  task automatic test_latency();
    logic [31:0] got; logic e; int w;
    do_req(1, 1'b1, 32'h0C, 2'd2, 1'b0, 32'hCAFEBABE, got, e, w);
    do_req(1, 1'b0, 32'h0E, 2'd1, 1'b1, 32'h0, got, e, w);
    n_tests++;
    if (w !== 0 || got !== 32'h0000CAFE) begin
      n_fail++;
      $display("FAIL latency_second: wait=%0d rdata=%h, required 0 0000CAFE", w, got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got; logic e; int w;
    int cnt;
    logic saw;
    do_req(2, 1'b1, 32'h08, 2'd2, 1'b0, 32'hCAFEF00D, got, e, w);
    w_write = 1'b0; w_addr = 32'h08; w_size = 2'd2; w_uns = 1'b0;
    valid[2] = 1'b1;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    model_clear(2);
    saw = 1'b0;
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      if (rv[2] !== 1'b0) saw = 1'b1;
      if (rdy[2] === 1'b1) break;
      cnt++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: resp_valid seen after reset, required none");
    end
    n_tests++;
    if (cnt !== D2) begin
      n_fail++;
      $display("FAIL reset_reclear: ready rose after %0d cycles, required %0d", cnt, D2);
    end
    do_req(2, 1'b0, 32'h08, 2'd2, 1'b0, 32'h0, got, e, w);
    n_tests++;
    if (got !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cleared: rdata=%h, required 00000000", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] got; logic e; int w;
    int k, r;
    logic [1:0] s;
    logic [31:0] a;
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      s = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = 32'($urandom_range(0, 4 * dep[k] + 7));
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
      do_req(k, 1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom, got, e, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
